bldc_commutator: RTL
====================

# bldc_commutator

Three-phase brushless-DC commutator directly downstream of the 11-bit PWM generator. It consumes `PWM_sig` and the once-per-period `PWM_synch` pulse, together with the asynchronous hall-sensor inputs. It produces the six gate-drive signals, changing the phase pattern only at PWM period boundaries and inserting a dead-time gap on every pattern change. It also flags invalid hall codes.

## Interface
Parameters:
- `DEADTIME`, default 8: number of clk cycles all six drives are held low between patterns; legal range 1..255.

Ports:
- `clk`  in  1: 50 MHz system clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `hall`  in  3: hall sensors {A,B,C}; asynchronous to `clk`.
- `PWM_sig`  in  1: PWM waveform from the PWM generator.
- `PWM_synch`  in  1: one-cycle pulse, once per 2048-cycle PWM period.
- `forward`  in  1: 1 = forward rotation, 0 = reverse.
- `brake_n`  in  1: active-low brake request.
- `highA`, `lowA`, `highB`, `lowB`, `highC`, `lowC`  out  1 each: registered gate drives.
- `hall_err`  out  1: sticky flag, set on an invalid hall code.

## Operation
- Hall synchronization: `hall` passes through a two-flop synchronizer. The synchronized value, `forward` and `brake_n` are captured into `hall_q`/`fwd_q`/`brk_q` only in a cycle where `PWM_synch`=1.
- Sector decode of `hall_q`:
  - 101→0, 100→1, 110→2, 010→3, 011→4, 001→5.
  - 000 and 111 are invalid.
- Forward pattern (the high side carries PWM, the low side is solidly on, the third phase is off):
  - Sector 0: highA/lowB.
  - Sector 1: highA/lowC.
  - Sector 2: highB/lowC.
  - Sector 3: highB/lowA.
  - Sector 4: highC/lowA.
  - Sector 5: highC/lowB.
- Reverse pattern: the same phase pair per sector with the roles swapped. Example: sector 0 reverse = highB/lowA.
- Brake (`brk_q`=0): all high sides off; lowA=lowB=lowC follow PWM. Brake takes priority over sector decode.
- Active high side output = `PWM_sig` delayed by one flop. Active low side = 1. All other drives = 0.
- State machine:
  - IDLE: after reset, all drives off. On the first `PWM_synch` with a valid code, go to DEAD.
  - DEAD: all drives 0; the counter loads `DEADTIME`-1 and counts down; at 0 go to DRIVE with the latched target pattern.
  - DRIVE: output the current pattern. When the target recomputed from new `hall_q`/`fwd_q`/`brk_q` differs from the current pattern, go to DEAD. An identical target causes no transition and no gap.
  - FAULT: entered from any state when `hall_q` is invalid and not in brake. All drives 0; `hall_err`=1. Exited only by `rst`.
- Brake with an invalid hall code: brake pattern is applied and no fault is raised.
- Target change while in DEAD: the counter reloads and the new target replaces the old one. The full `DEADTIME` gap is restarted.
- Invariant: highX and lowX are never both 1 for any phase X, in any cycle.

## Timing
- Reset values: all six drives 0, `hall_err` 0, state IDLE, synchronizer and `hall_q` cleared to 000 (not treated as a fault until the first `PWM_synch` capture).
- `rst` asserted mid-operation: all outputs 0 on the next edge.
- Hall-to-capture delay: an edge on `hall` is eligible for capture 2 cycles later; it is captured on the next `PWM_synch`.
- Pattern switching: let T be the cycle with `PWM_synch`=1 that captures a new code.
  - Drives are 0 from the edge at T+2.
  - They stay 0 for exactly `DEADTIME` cycles.
  - The new pattern is visible from T+2+`DEADTIME`.
- `PWM_sig` to active high-side drive: 1 cycle latency.
- Entering FAULT: drives go to 0 at T+2.

## Structure
- Package `bldc_pkg` holds:
  - The state enum (IDLE, DEAD, DRIVE, FAULT).
  - A packed 6-bit drive-pattern typedef {hA,lA,hB,lB,hC,lC}.
  - Sector-to-pattern constants, plus a decode function taking (hall, fwd, brk).
- Sub-module `hall_sync`: two-flop synchronizer plus the `PWM_synch`-gated capture register for `hall`/`forward`/`brake_n`.

## Test plan
- Reset, then hall=101, forward=1, `DEADTIME`=8, one `PWM_synch` → 8 cycles all-zero, then highA=`PWM_sig` (1-cycle delayed), lowB=1, others 0.
- Change hall 101→100 mid-period → no drive change until the next `PWM_synch`; then 8 zero cycles; then highA/lowC.
- forward=0, hall=110 → highC/lowB (reverse of sector 2); toggle forward back to 1 → dead gap, then highB/lowC.
- brake_n=0 at a `PWM_synch`, with hall=111 → all high sides 0, lows follow `PWM_sig`, `hall_err` stays 0.
- hall=000 captured with brake_n=1 → drives 0 and `hall_err`=1 from T+2; stays set through later valid codes until `rst`.
- Random hall/forward/brake_n sequences over 200 PWM periods → assertion that highX & lowX is never 1, and every pattern change is preceded by ≥8 all-zero cycles.

Source files
------------

// File: rtl/bldc_pkg.sv
// bldc_pkg: shared state, drive-pattern types and hall decode
// for the three-phase BLDC commutator.
package bldc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    DRIVE,
    FAULT
  } state_e;

  typedef struct packed {
    logic hA;
    logic lA;
    logic hB;
    logic lB;
    logic hC;
    logic lC;
  } pat_t;

  typedef struct packed {
    logic ok;
    pat_t pat;
  } tgt_t;

  localparam pat_t PAT_OFF = 6'b000000;
  localparam pat_t PAT_BRK = 6'b010101;
  localparam pat_t PAT_AB  = 6'b100100;
  localparam pat_t PAT_AC  = 6'b100001;
  localparam pat_t PAT_BC  = 6'b001001;
  localparam pat_t PAT_BA  = 6'b011000;
  localparam pat_t PAT_CA  = 6'b010010;
  localparam pat_t PAT_CB  = 6'b000110;

  // Brake wins over the hall code, so a bad code
  // under brake is still a usable target.
  function automatic tgt_t decode(
    input logic [2:0] hall,
    input logic       fwd,
    input logic       brk_n
  );
    tgt_t t;
    t.ok  = 1'b1;
    t.pat = PAT_OFF;
    if (!brk_n) begin
      t.pat = PAT_BRK;
    end else begin
      unique case (hall)
        3'b101:  t.pat = fwd ? PAT_AB : PAT_BA;
        3'b100:  t.pat = fwd ? PAT_AC : PAT_CA;
        3'b110:  t.pat = fwd ? PAT_BC : PAT_CB;
        3'b010:  t.pat = fwd ? PAT_BA : PAT_AB;
        3'b011:  t.pat = fwd ? PAT_CA : PAT_AC;
        3'b001:  t.pat = fwd ? PAT_CB : PAT_BC;
        default: t.ok  = 1'b0;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/hall_sync.sv
// hall_sync: two-flop hall synchronizer plus PWM-period capture.
// Ports: hall/fwd/brake in, captured copies and cap_o out.
module hall_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall_i,
  input  logic       fwd_i,
  input  logic       brk_n_i,
  input  logic       synch_i,
  output logic [2:0] hall_o,
  output logic       fwd_o,
  output logic       brk_n_o,
  output logic       cap_o
);

  logic [2:0] s1_q;
  logic [2:0] s2_q;
  logic [2:0] hall_q;
  logic       fwd_q;
  logic       brk_q;
  logic       cap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      hall_q <= '0;
      fwd_q  <= 1'b0;
      brk_q  <= 1'b0;
      cap_q  <= 1'b0;
    end else begin
      s1_q <= hall_i;
      s2_q <= s1_q;
      if (synch_i) begin
        hall_q <= s2_q;
        fwd_q  <= fwd_i;
        brk_q  <= brk_n_i;
        cap_q  <= 1'b1;
      end
    end
  end

  assign hall_o  = hall_q;
  assign fwd_o   = fwd_q;
  assign brk_n_o = brk_q;
  assign cap_o   = cap_q;

endmodule

// File: rtl/bldc_commutator.sv
// bldc_commutator: hall-driven six-step gate drive with dead time.
// Ports: clk/rst, hall, PWM_sig/PWM_synch, forward, brake_n -> drives, hall_err.
module bldc_commutator
  import bldc_pkg::*;
#(
  parameter int DEADTIME = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall,
  input  logic       PWM_sig,
  input  logic       PWM_synch,
  input  logic       forward,
  input  logic       brake_n,
  output logic       highA,
  output logic       lowA,
  output logic       highB,
  output logic       lowB,
  output logic       highC,
  output logic       lowC,
  output logic       hall_err
);

  localparam logic [7:0] DT_M1 = 8'(DEADTIME - 1);

  logic [2:0] hall_s;
  logic       fwd_s;
  logic       brk_s;
  logic       cap_s;

  hall_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .hall_i  (hall),
    .fwd_i   (forward),
    .brk_n_i (brake_n),
    .synch_i (PWM_synch),
    .hall_o  (hall_s),
    .fwd_o   (fwd_s),
    .brk_n_o (brk_s),
    .cap_o   (cap_s)
  );

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  pat_t       pat_q, pat_d;
  pat_t       drv_q, drv_d;
  logic       err_q;
  tgt_t       tgt;

  assign tgt = decode(hall_s, fwd_s, brk_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= PAT_OFF;
      drv_q   <= PAT_OFF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      drv_q   <= drv_d;
      err_q   <= (state_d == FAULT);
    end
  end

  // pat_q is the target while in DEAD and the live
  // pattern while in DRIVE; a new target restarts the gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    if (cap_s && !tgt.ok) begin
      state_d = FAULT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cap_s) begin
            state_d = DEAD;
            cnt_d   = DT_M1;
            pat_d   = tgt.pat;
          end
        end
        DEAD: begin
          if (tgt.pat != pat_q) begin
            cnt_d = DT_M1;
            pat_d = tgt.pat;
          end else if (cnt_q == 8'd0) begin
            state_d = DRIVE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        DRIVE: begin
          if (tgt.pat != pat_q) begin
            state_d = DEAD;
            cnt_d   = DT_M1;
            pat_d   = tgt.pat;
          end
        end
        FAULT: state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    drv_d = PAT_OFF;
    if (state_d == DRIVE) begin
      if (pat_d == PAT_BRK) begin
        drv_d.lA = PWM_sig;
        drv_d.lB = PWM_sig;
        drv_d.lC = PWM_sig;
      end else begin
        drv_d    = pat_d;
        drv_d.hA = pat_d.hA & PWM_sig;
        drv_d.hB = pat_d.hB & PWM_sig;
        drv_d.hC = pat_d.hC & PWM_sig;
      end
    end
  end

  assign highA    = drv_q.hA;
  assign lowA     = drv_q.lA;
  assign highB    = drv_q.hB;
  assign lowB     = drv_q.lB;
  assign highC    = drv_q.hC;
  assign lowC     = drv_q.lC;
  assign hall_err = err_q;

endmodule
